// File: rtl/morse_pkg.sv
// Shared Morse framing constants: code/length widths, symbol encoding and the
// default timing used by the matching transmitter.
package morse_pkg;

    localparam int MORSE_CODE_W = 8;
    localparam int MORSE_LEN_W  = 4;

    typedef enum logic {
        SYM_DOT  = 1'b0,
        SYM_DASH = 1'b1
    } sym_t;

    localparam int DEF_DOT_LEN  = 1;
    localparam int DEF_DASH_LEN = 3;
    localparam int DEF_CHAR_GAP = 3;
    localparam int DEF_WORD_GAP = 7;
    localparam int DEF_MAX_SYM  = 8;

endpackage

// File: rtl/morse_run_cnt.sv
// Saturating run-length counter: counts consecutive cycles with level=1 and
// flags the first cycle of a run (rise) and the first cycle after it (fall).
module morse_run_cnt #(
    parameter int LIMIT = 4,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             level,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             rise,
    output logic             fall
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    always_comb begin
        count_nxt = '0;
        if (level) begin
            count_nxt = (count == LIM) ? count : count + CNT_W'(1);
        end
    end

    assign rise = level && (count == '0);
    assign fall = !level && (count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: classifies LED on/off runs into dots, dashes and gaps and
// emits each character as an MSB-first code plus symbol count.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_LEN  = DEF_DOT_LEN,
    parameter int DASH_LEN = DEF_DASH_LEN,
    parameter int CHAR_GAP = DEF_CHAR_GAP,
    parameter int WORD_GAP = DEF_WORD_GAP,
    parameter int MAX_SYM  = DEF_MAX_SYM
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    led_in,
    output logic                    char_vald,
    output logic [MORSE_CODE_W-1:0] charcode_data,
    output logic [MORSE_LEN_W-1:0]  charlen_data,
    output logic                    char_err
);

    localparam int ON_W  = $clog2(DASH_LEN + 2);
    localparam int OFF_W = $clog2(WORD_GAP + 1);

    localparam logic [ON_W-1:0]         DOT_C    = ON_W'(DOT_LEN);
    localparam logic [ON_W-1:0]         DASH_C   = ON_W'(DASH_LEN);
    localparam logic [OFF_W-1:0]        CHAR_C   = OFF_W'(CHAR_GAP);
    localparam logic [OFF_W-1:0]        WORD_C   = OFF_W'(WORD_GAP);
    localparam logic [MORSE_LEN_W-1:0]  MAX_C    = MORSE_LEN_W'(MAX_SYM);
    localparam logic [MORSE_CODE_W-1:0] CODE_MSB = {1'b1, {(MORSE_CODE_W-1){1'b0}}};

    logic [ON_W-1:0]         on_cnt, on_cnt_nxt;
    logic [OFF_W-1:0]        off_cnt, off_cnt_nxt;
    logic                    on_rise, on_fall, off_rise, off_fall;
    logic [MORSE_CODE_W-1:0] shreg, shreg_nxt;
    logic [MORSE_LEN_W-1:0]  sym_cnt, sym_nxt;
    logic                    bad, bad_nxt, armed;
    logic                    char_hit, word_hit, end_char;
    sym_t                    sym;
    logic                    unused_run_sigs;

    morse_run_cnt #(.LIMIT(DASH_LEN + 1), .CNT_W(ON_W)) u_on_run (
        .clock     (clock),
        .reset     (reset),
        .level     (led_in),
        .count     (on_cnt),
        .count_nxt (on_cnt_nxt),
        .rise      (on_rise),
        .fall      (on_fall)
    );

    morse_run_cnt #(.LIMIT(WORD_GAP), .CNT_W(OFF_W)) u_off_run (
        .clock     (clock),
        .reset     (reset),
        .level     (!led_in),
        .count     (off_cnt),
        .count_nxt (off_cnt_nxt),
        .rise      (off_rise),
        .fall      (off_fall)
    );

    assign unused_run_sigs = ^{on_cnt_nxt, on_rise, off_rise, off_fall};

    // Symbol classification folds into the same edge as end-of-character,
    // so a character ending on a short CHAR_GAP still sees its last symbol.
    always_comb begin
        sym       = (on_cnt == DASH_C) ? SYM_DASH : SYM_DOT;
        sym_nxt   = sym_cnt;
        shreg_nxt = shreg;
        bad_nxt   = bad;
        if (on_fall) begin
            if (on_cnt != DOT_C && on_cnt != DASH_C) begin
                bad_nxt = 1'b1;
            end else if (sym_cnt == MAX_C) begin
                bad_nxt = 1'b1;
            end else begin
                if (sym == SYM_DASH) begin
                    shreg_nxt = shreg | (CODE_MSB >> sym_cnt);
                end
                sym_nxt = sym_cnt + MORSE_LEN_W'(1);
            end
        end
    end

    assign char_hit = (off_cnt_nxt == CHAR_C) && (off_cnt != CHAR_C);
    assign word_hit = (off_cnt_nxt == WORD_C) && (off_cnt != WORD_C) && armed;
    assign end_char = char_hit && ((sym_nxt != '0) || bad_nxt);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg         <= '0;
            sym_cnt       <= '0;
            bad           <= 1'b0;
            armed         <= 1'b0;
            char_vald     <= 1'b0;
            char_err      <= 1'b0;
            charcode_data <= '0;
            charlen_data  <= '0;
        end else begin
            char_vald <= 1'b0;
            char_err  <= 1'b0;
            shreg     <= shreg_nxt;
            sym_cnt   <= sym_nxt;
            bad       <= bad_nxt;
            if (end_char) begin
                shreg   <= '0;
                sym_cnt <= '0;
                bad     <= 1'b0;
                if (bad_nxt) begin
                    char_err <= 1'b1;
                end else begin
                    char_vald     <= 1'b1;
                    charcode_data <= shreg_nxt;
                    charlen_data  <= sym_nxt;
                    armed         <= 1'b1;
                end
            end else if (word_hit) begin
                char_vald     <= 1'b1;
                charcode_data <= '0;
                charlen_data  <= '0;
                armed         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: a run-length reference model checked
// every cycle, plus literal expectations on the decoded event stream.
module tb_morse_decoder;

    localparam int DOT_LEN  = 1;
    localparam int DASH_LEN = 3;
    localparam int CHAR_GAP = 3;
    localparam int WORD_GAP = 7;
    localparam int MAX_SYM  = 8;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       led_in = 1'b0;
    logic       char_vald, char_err;
    logic [7:0] charcode_data;
    logic [3:0] charlen_data;

    morse_decoder dut (
        .clock         (clock),
        .reset         (reset),
        .led_in        (led_in),
        .char_vald     (char_vald),
        .charcode_data (charcode_data),
        .charlen_data  (charlen_data),
        .char_err      (char_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] code;
        logic [3:0] len;
        logic       err;
        int         cyc;
    } ev_t;
    ev_t log_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: whole run lengths, symbols kept as a list.
    int         m_on = 0, m_off = 0;
    bit         m_syms[$];
    bit         m_bad = 0, m_armed = 0;
    logic       m_vald = 0, m_err = 0;
    logic [7:0] m_code = 0;
    logic [3:0] m_len = 0;

    function automatic logic [7:0] pack_syms(input bit s[$]);
        logic [7:0] p = '0;
        for (int i = 0; i < s.size(); i++) p[7-i] = s[i];
        return p;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_on = 0; m_off = 0; m_syms.delete(); m_bad = 0; m_armed = 0;
            m_vald = 0; m_err = 0; m_code = 0; m_len = 0;
        end else begin
            cyc <= cyc + 1;
            m_vald = 0;
            m_err  = 0;
            if (led_in) begin
                m_on++;
                m_off = 0;
            end else begin
                if (m_on > 0) begin
                    if (m_on != DOT_LEN && m_on != DASH_LEN) m_bad = 1;
                    else if (m_syms.size() == MAX_SYM) m_bad = 1;
                    else m_syms.push_back(bit'(m_on == DASH_LEN));
                    m_on = 0;
                end
                m_off++;
                if (m_off == CHAR_GAP && (m_syms.size() > 0 || m_bad)) begin
                    if (m_bad) begin
                        m_err = 1;
                    end else begin
                        m_vald  = 1;
                        m_code  = pack_syms(m_syms);
                        m_len   = 4'(m_syms.size());
                        m_armed = 1;
                    end
                    m_syms.delete();
                    m_bad = 0;
                end else if (m_off == WORD_GAP && m_armed) begin
                    m_vald = 1; m_code = 0; m_len = 0; m_armed = 0;
                end
            end
        end
    end

    always @(posedge clock) begin
        #2;
        chk("char_vald", char_vald, m_vald);
        chk("char_err", char_err, m_err);
        chk("charcode_data", charcode_data, m_code);
        chk("charlen_data", charlen_data, m_len);
        chk("vald_err_exclusive", char_vald & char_err, 0);
        if (char_vald || char_err)
            log_q.push_back('{code: charcode_data, len: charlen_data, err: char_err, cyc: cyc});
    end

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            led_in = (s[i] == "1");
            @(negedge clock);
        end
    endtask

    task automatic lows(input int n);
        led_in = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_ev(input string nm, input int idx, input logic [7:0] c,
                          input logic [3:0] l, input logic e, input int t);
        if (idx >= log_q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d events, expected event %0d", nm, log_q.size(), idx);
        end else begin
            chk({nm, "_code"}, log_q[idx].code, c);
            chk({nm, "_len"}, log_q[idx].len, l);
            chk({nm, "_err"}, log_q[idx].err, e);
            if (t >= 0) chk({nm, "_cycle"}, log_q[idx].cyc, t);
        end
    endtask

    task automatic send_char(input logic [7:0] code, input int len);
        for (int k = 0; k < len; k++) begin
            led_in = 1'b1;
            repeat (code[7-k] ? DASH_LEN : DOT_LEN) @(negedge clock);
            led_in = 1'b0;
            @(negedge clock);
        end
        lows(CHAR_GAP - 1);
    endtask

    // "M16 TA FATIMA"
    logic [7:0] lb_code[13] = '{8'hC0, 8'h78, 8'h80, 8'h00, 8'h80, 8'h40, 8'h00,
                                8'h20, 8'h40, 8'h80, 8'h00, 8'hC0, 8'h40};
    int         lb_len[13]  = '{2, 5, 5, 0, 1, 2, 0, 4, 2, 1, 2, 2, 2};

    int t;

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_vald", char_vald, 0);
        chk("rst_err", char_err, 0);
        chk("rst_code", charcode_data, 0);
        chk("rst_len", charlen_data, 0);
        reset = 1'b1;

        lows(20);
        chk("idle_events", log_q.size(), 0);

        log_q.delete();
        send("1110111000");
        t = cyc;
        lows(7);
        chk_ev("m_char", 0, 8'hC0, 4'd2, 1'b0, t);
        chk_ev("m_space", 1, 8'h00, 4'd0, 1'b0, t + 4);
        chk("m_count", log_q.size(), 2);

        log_q.delete();
        send("10111000");
        t = cyc;
        lows(17);
        chk_ev("a_char", 0, 8'h40, 4'd2, 1'b0, t);
        chk_ev("a_space", 1, 8'h00, 4'd0, 1'b0, t + 4);
        chk("a_count", log_q.size(), 2);

        log_q.delete();
        send("10111011101110111000");
        t = cyc;
        chk_ev("one_char", 0, 8'h78, 4'd5, 1'b0, t);
        send("11000");
        t = cyc;
        chk_ev("short_run_err", 1, 8'h78, 4'd5, 1'b1, t);
        chk("err_holds_code", charcode_data, 8'h78);
        lows(14);
        chk_ev("space_after_err", 2, 8'h00, 4'd0, 1'b0, t + 4);
        chk("one_count", log_q.size(), 3);

        log_q.delete();
        send("10101010101010101000");
        t = cyc;
        lows(10);
        chk_ev("overflow_err", 0, 8'h00, 4'd0, 1'b1, t);
        chk("overflow_count", log_q.size(), 1);

        log_q.delete();
        send("1001000");
        t = cyc;
        lows(10);
        chk_ev("gap2_char", 0, 8'h00, 4'd2, 1'b0, t);
        chk("gap2_count", log_q.size(), 2);

        log_q.delete();
        for (int i = 0; i < 13; i++) begin
            if (lb_len[i] == 0) lows(WORD_GAP - CHAR_GAP);
            else send_char(lb_code[i], lb_len[i]);
        end
        lows(10);
        for (int i = 0; i < 13; i++)
            chk_ev($sformatf("loop_%0d", i), i, lb_code[i], 4'(lb_len[i]), 1'b0, -1);
        chk("loop_count", log_q.size(), 14);

        log_q.delete();
        send("1110111000");
        t = cyc;
        send("111011");
        reset = 1'b0;
        led_in = 1'b1;
        @(negedge clock);
        chk("midrst_vald", char_vald, 0);
        reset = 1'b1;
        lows(20);
        chk_ev("pre_rst_char", 0, 8'hC0, 4'd2, 1'b0, t);
        chk("midrst_count", log_q.size(), 1);

        lows(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
